mul_iter_hs: RTL
================

// Module: mul_iter_hs
// PURPOSE
//  Parametrised iterative multiplier with valid/ready handshake on both sides; next generation of the single-cycle multiplyer.
//  Accepts WIDTH-bit operands (signed or unsigned per op) and returns a 2*WIDTH-bit product after a fixed multi-cycle latency.
//  Processes BPC multiplier bits per cycle, trading latency for area; sits in the CPU execute stage, with cancel for pipeline flush.
// PARAMETERS
//  WIDTH  32  operand width; even, >=8
//  BPC    4   multiplier bits consumed per BUSY cycle; must divide WIDTH (1,2,4,8)
// PORTS
//  mul_clk     in   1        sole clock, rising edge
//  reset       in   1        synchronous, active-high reset
//  in_valid    in   1        operand request valid
//  in_ready    out  1        block can accept an operand request
//  x           in   WIDTH    multiplicand
//  y           in   WIDTH    multiplier
//  mul_signed  in   1        1: x,y two's complement; 0: unsigned
//  cancel      in   1        abort in-flight/pending op (pipeline flush)
//  out_valid   out  1        result valid
//  out_ready   in   1        consumer takes result
//  result      out  2*WIDTH  product x*y
// BEHAVIOUR
//  - Clock is mul_clk; reset is synchronous and active-high. Reset: state=IDLE, out_valid=0, acc/result=0, counter=0.
//  - N = WIDTH/BPC. States IDLE, BUSY, DONE.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); combinational, never depends on in_valid.
//  - Accept = in_valid & in_ready. On accept: latch |x|,|y| (magnitude if mul_signed & msb, else raw bits),
//    neg = mul_signed & (x[W-1]^y[W-1]), acc=0, cnt=0, go BUSY. Operands need not be held after accept.
//  - BUSY: each cycle acc += (ymag[BPC-1:0] * xmag) << (cnt*BPC); ymag >>= BPC; cnt++.
//    After N BUSY cycles go DONE. Accept at edge k -> out_valid=1 from edge k+N+1.
//  - DONE: out_valid=1; result = neg ? -acc : acc (2*WIDTH-bit two's complement, mod 2^(2W)).
//    result and out_valid stable while out_ready=0. Leave DONE on out_ready: to BUSY if same-cycle accept, else IDLE.
//  - Magnitude of most-negative value (0x80..0) equals its unsigned bits; product stays exact in 2*WIDTH bits.
//  - cancel: highest priority below reset; next state IDLE, out_valid=0, no accept in that cycle (in_ready forced 0 when cancel=1).
//  - in_valid during BUSY: ignored (in_ready=0); requester must hold.
//  - result is don't-care while out_valid=0, but must be driven only from registers plus final negation.
// STRUCTURE
//  - mul_pkg: state enum {IDLE,BUSY,DONE}, function clog2, localparam-derivation of N and counter width.
//  - One sub-module mul_step: combinational BPC-bit x WIDTH partial-product generator/adder
//    (in: acc, xmag, ybits, shift; out: acc_next). Top holds FSM, counter, operand/acc registers, negation.
// TESTING  (WIDTH=32, BPC=4, N=8)
//  T1 unsigned x=0xFFFFFFFF,y=0xFFFFFFFF -> out_valid 9 cycles after accept, result=0xFFFFFFFE00000001.
//  T2 signed x=0x80000000,y=0x80000000 -> 0x4000000000000000; x=0x80000000,y=1 -> 0xFFFFFFFF80000000; -1*-1 -> 1.
//  T3 backpressure: hold out_ready=0 five cycles in DONE -> result/out_valid unchanged, in_ready=0; release -> IDLE.
//  T4 back-to-back: DONE with out_ready=1 and in_valid=1 (3*5 unsigned) -> first result taken, 15 appears 9 cycles later.
//  T5 cancel at BUSY cycle 3 -> IDLE next cycle, out_valid never rises, next op 7*(-2) signed -> 0xFFFFFFFFFFFFFFF2.
//  T6 reset asserted mid-BUSY -> all outputs reset next edge; random signed/unsigned sweep vs. reference model, 10k ops.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and elaboration-time helpers for the iterative multiplier.
// Derives the step count and counter width from WIDTH and BPC.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BPC   = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    function automatic int calc_n(input int width, input int bpc);
        return width / bpc;
    endfunction

    // The counter must reach N, which is the extra result-latching cycle.
    function automatic int calc_cnt_w(input int width, input int bpc);
        return clog2(calc_n(width, bpc) + 1);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2^BPC step: adds (ybits * xmag) << shift to the running accumulator.
// Purely combinational; the top owns all state.
module mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 4,
    parameter int SHW   = 6
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   xmag,
    input  logic [BPC-1:0]     ybits,
    input  logic [SHW-1:0]     shift,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH+BPC-1:0] pp_s;
    logic [2*WIDTH-1:0]   pp_wide_s;

    // Narrow partial product, widened and aligned before accumulation.
    always_comb begin
        pp_s      = (WIDTH+BPC)'(xmag) * (WIDTH+BPC)'(ybits);
        pp_wide_s = (2*WIDTH)'(pp_s);
        acc_next  = acc + (pp_wide_s << shift);
    end

endmodule

// File: rtl/mul_iter_hs.sv
// Iterative signed/unsigned multiplier with valid/ready handshakes and flush.
// Magnitudes are multiplied BPC bits per cycle; the sign is applied once at the end.
module mul_iter_hs
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BPC   = DEF_BPC
) (
    input  logic               mul_clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               mul_signed,
    input  logic               cancel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int N   = calc_n(WIDTH, BPC);
    localparam int CW  = calc_cnt_w(WIDTH, BPC);
    localparam int SHW = clog2(2 * WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N);
    localparam logic [SHW-1:0] BPC_L    = SHW'(BPC);

    state_t               state_r;
    state_t               state_n_s;
    logic [CW-1:0]        cnt_r;
    logic [WIDTH-1:0]     xmag_r;
    logic [WIDTH-1:0]     ymag_r;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 out_valid_r;
    logic                 in_ready_s;
    logic                 accept_s;
    logic [2*WIDTH-1:0]   acc_next_s;
    logic [SHW-1:0]       shift_s;

    // 0x80..0 maps onto itself, which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    // Handshake acceptance; cancel blocks any same-cycle accept.
    always_comb begin
        in_ready_s = 1'b0;
        if (cancel) begin
            in_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if ((state_r == DONE) && out_ready) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
        shift_s  = SHW'(cnt_r) * BPC_L;
    end

    mul_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .SHW   (SHW)
    ) u_step (
        .acc      (acc_r),
        .xmag     (xmag_r),
        .ybits    (ymag_r[BPC-1:0]),
        .shift    (shift_s),
        .acc_next (acc_next_s)
    );

    // State register.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic; BUSY spans N step cycles plus one result-latching cycle.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_n_s = BUSY;
                else          state_n_s = IDLE;
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) state_n_s = DONE;
                else                   state_n_s = BUSY;
            end
            DONE: begin
                if (!out_ready)    state_n_s = DONE;
                else if (accept_s) state_n_s = BUSY;
                else               state_n_s = IDLE;
            end
            default: state_n_s = IDLE;
        endcase
        if (cancel) begin
            state_n_s = IDLE;
        end
    end

    // Operand capture, accumulation and registered result/valid.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            cnt_r       <= '0;
            xmag_r      <= '0;
            ymag_r      <= '0;
            neg_r       <= 1'b0;
            acc_r       <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else if (cancel) begin
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            xmag_r      <= magnitude(x, mul_signed);
            ymag_r      <= magnitude(y, mul_signed);
            neg_r       <= mul_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
            acc_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (state_r == BUSY) begin
            if (cnt_r == CNT_LAST) begin
                result_r    <= neg_r ? -acc_r : acc_r;
                out_valid_r <= 1'b1;
            end else begin
                acc_r  <= acc_next_s;
                ymag_r <= ymag_r >> BPC;
                cnt_r  <= cnt_r + CW'(1);
            end
        end else if ((state_r == DONE) && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule
